// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder controller.
package cla_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned nslice(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice shared by every nibble.
module cla4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a4 & b4;
        p    = a4 ^ b4;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
        s4   = p ^ c[3:0];
        co   = c[4];
    end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a shared CLA slice.
// Define CLA_SEQ_SUB_EN to add the 'sub' port (a - b via inverted b, carry-in 1).
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSLICE = nslice(WIDTH);
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
    logic [IDXW-1:0]   idx;
    logic              carry, cout_reg;
    logic              sub_en;
    logic              last;
    logic              accept;
    logic [3:0]        s4;
    logic              co;

`ifdef CLA_SEQ_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif

    assign last   = (idx == IDXW'(NSLICE - 1));
    assign accept = in_valid && (state == IDLE);

    cla4_slice u_slice (
        .a4 (a_reg[SLICE_W*idx +: SLICE_W]),
        .b4 (b_reg[SLICE_W*idx +: SLICE_W]),
        .ci (carry),
        .s4 (s4),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
        end else if (accept) begin
            // Subtraction folds into the add: invert b once and force carry-in.
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub_en}};
            carry <= sub_en ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_reg[SLICE_W*idx +: SLICE_W] <= s4;
            carry <= co;
            if (last) begin
                cout_reg <= co;
                idx      <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed bench for cla_seq_adder_ctrl (WIDTH=16); exercises sub when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_adder_ctrl;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          cin;
`ifdef CLA_SEQ_SUB_EN
    logic          sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input logic os, input logic [W-1:0] es, input logic ec,
                         input string name);
        int unsigned lat;
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        a        = oa;
        b        = ob;
        cin      = oc;
`ifdef CLA_SEQ_SUB_EN
        sub      = os;
`else
        if (os) $display("note: sub requested without CLA_SEQ_SUB_EN");
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub      = 1'b0;
`endif
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, " latency"}, lat, 32'd4);
        check({name, " sum"}, {16'd0, sum}, {16'd0, es});
        check({name, " cout"}, {31'd0, cout}, {31'd0, ec});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " idle"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        check("reset sum", {16'd0, sum}, 32'd0);
        check("reset flags", {29'd0, cout, out_valid, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 7; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].c,
                  $sformatf("vec%0d", i));

        // Backpressure: hold DONE for 3 cycles while offering new operands.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
            check($sformatf("bp%0d valid/ready", k), {30'd0, out_valid, in_ready}, 32'b10);
            check($sformatf("bp%0d sum", k), {15'd0, cout, sum}, 32'h05555);
            tick();
        end
        in_valid = 1'b0;
        check("bp still done", {30'd0, out_valid, in_ready}, 32'b10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp released", {30'd0, out_valid, in_ready}, 32'b01);
        check("bp no capture", {16'd0, sum}, 32'h5555);

        // Reset while RUN is on nibble 2.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst-run sum", {16'd0, sum}, 32'd0);
        check("rst-run flags", {28'd0, cout, out_valid, busy, in_ready}, 32'b0001);
        tick();
        check("rst-run stays idle", {30'd0, out_valid, busy}, 32'd0);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "post-rst");

`ifdef CLA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub 5-7");
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub 7-5");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder_ctrl.md
Name: cla_seq_adder_ctrl

Overview:
Multi-cycle controller that computes a WIDTH-bit add using one shared 4-bit carry-lookahead slice. It processes one 4-bit nibble per cycle, least-significant nibble first, and holds the carry in a register between nibbles. It sits between an operand producer and a result consumer, with a valid/ready handshake on both sides. It trades latency for area when WIDTH-bit adders are too costly.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived nibble count; not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the most-significant nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state←IDLE; sum←0; cout←0; out_valid←0; busy←0; nibble index←0; carry reg←0.
  - Reset overrides everything, including mid-RUN; the in-flight operation is discarded and no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b, cin into operand regs; idx←0; carry←cin; →RUN.
  - Inputs are ignored while in_ready=0.
- RUN:
  - in_ready=0.
  - Each cycle, the slice adds a_reg[4*idx+:4] + b_reg[4*idx+:4] + carry.
  - Nibble result is written to sum_reg[4*idx+:4]; carry←slice cout; idx←idx+1.
  - At idx==NSLICE-1: write the final nibble, cout←slice cout, →DONE.
- DONE:
  - out_valid=1; sum and cout are stable and held.
  - On out_ready: →IDLE, out_valid←0.
  - No bypass: a new operand is accepted no earlier than the cycle after the result handshake.
- Latency: out_valid rises NSLICE cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one result per NSLICE+2 cycles when out_ready=1.
- sum during RUN holds partial/stale nibbles; it is valid only while out_valid=1.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- WIDTH=4: RUN lasts exactly one cycle.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- With the macro defined:
  - Adds input port sub (1 bit), sampled with the operands.
  - When sub=1: b is inverted at latch time, carry←1 (cin ignored), and the result is a−b mod 2^WIDTH.
  - cout=1 means no borrow (a≥b).
- Without the macro: no sub port; add only.

Decomposition:
- Package cla_seq_pkg:
  - SLICE_W=4.
  - State enum {IDLE, RUN, DONE}.
  - Function computing NSLICE.
- One sub-module, cla4_slice: purely combinational 4-bit adder with generate/propagate lookahead carries (inputs a4, b4, ci; outputs s4, co), instantiated once.
- Controller holds the FSM, operand regs, idx counter, carry reg and result reg.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles via the carry reg).
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0x0F0F, b=0x00F1, cin=0 -> sum=0x1000, cout=0.
- Backpressure: out_ready held low 3 cycles in DONE -> out_valid, sum, cout stable, in_ready=0, a new in_valid is ignored; on out_ready=1, IDLE next cycle and in_ready=1.
- Reset at RUN idx=2 -> next cycle: state IDLE, out_valid=0, sum=0, cout=0, busy=0; a new operation then completes correctly.
- CLA_SEQ_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
